ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered, handshaked successor to the combinational control decoder.
- Decodes the instruction class into the datapath control bundle and holds it in an output pipeline register with valid/ready flow control.
- Tracks in-flight loads in a parametrised scoreboard and stalls on load-use hazards.
- Supports pipeline flush from branch/jump resolution. Sits between fetch/register-read and execute.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 2, cycles after issue during which a load's rd is unavailable (1..8).
- ZERO_RD_NOWRITE, 1, when 1 force we_reg=0 for rd==0.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts instruction this cycle.
- op  in  7  opcode.
- instrType  in  3  class: 001 U, 010 J, 011 B, 100 I, 101 S, 110 R.
- funct3  in  3  funct3 field.
- rd, rs1, rs2  in  REG_AW each  register addresses.
- flush  in  1  kill held instruction; no capture this cycle.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  downstream accepts bundle.
- we_reg, pcControl, memory_en, aluAsel, aluBsel, jump, branch  out  1 each  registered controls.
- wdSelect  out  2  00 ALU, 01 memory, 10 PC+4, 11 imm.
- store_size  out  2  00 byte, 01 half, 10 word, 11 no store.
- illegal  out  1  unsupported instrType.
- out_rd  out  REG_AW  registered rd.
- stall  out  1  load-use hazard active (debug/perf).

Behaviour:
- All register updates are on the CLK rising edge. reset has priority over everything.
- Reset values:
  - out_valid=0, scoreboard empty.
  - Bundle outputs = defaults: we_reg=0, pcControl=0, wdSelect=00, aluBsel=0, aluAsel=1, memory_en=0, store_size=11, jump=0, branch=0, illegal=0, out_rd=0.
- Decode table. Fields not listed take the defaults.
  - U: we_reg=1. op=0010111 (AUIPC): aluAsel=0, wdSelect=00. Otherwise: wdSelect=11.
  - J: we_reg=1, pcControl=1, aluAsel=0, jump=1.
  - B: branch=1, pcControl=1, aluAsel=0, wdSelect=10.
  - I with op=1100111 (JALR): we_reg=1, pcControl=1, wdSelect=10, aluAsel=0, jump=1.
  - I with op=0000011 (load): we_reg=1, wdSelect=01, memory_en=1.
  - I with op=0010011: we_reg=1.
  - I with any other op: defaults.
  - S: memory_en=1. funct3 000→store_size 00, 001→01, 010→10, else 11.
  - R: aluBsel=1. we_reg=1 unless op is 1110011 or 0001111.
  - Any other instrType: defaults with illegal=1.
  - If ZERO_RD_NOWRITE=1 and rd==0: we_reg=0.
- Source use:
  - rs1 used by B, I, S, R.
  - rs2 used by B, S, R.
  - U and J use no sources.
- Hazard:
  - Condition: in_valid and a used source address (nonzero) matches any valid scoreboard entry.
  - Effect: stall=1, in_ready=0.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !stall & !flush.
  - capture = in_valid & in_ready. Output register loads the decoded bundle plus rd; out_valid←1.
  - out_fire = out_valid & out_ready & !flush.
  - If out_fire without capture: out_valid←0. Bundle fields hold their last value; only out_valid matters.
  - Latency: 1 cycle from capture to out_valid. Full throughput when there is no hazard.
- Flush: out_valid←0 and no capture that cycle. The scoreboard is not cleared, because issued loads are older than the flush.
- Scoreboard:
  - LOAD_LAT-deep shift register of {valid, rd}. It shifts every cycle; the oldest entry is dropped.
  - Insert at the head when out_fire and the held bundle is a load with we_reg=1.
  - A stalled instruction proceeds in the cycle its matching entry ages out.
- Simultaneous events:
  - Capture and out_fire in the same cycle replace the bundle; out_valid stays 1.
  - Insert and shift occur in the same cycle.
  - Flush together with a hazard: flush wins, stall still reported.
- Reset mid-operation discards the held instruction and all scoreboard entries.

Test Plan:
- Reset held 2 cycles, then released -> out_valid=0, store_size=11, aluAsel=1, in_ready=1.
- SW (instrType=101, funct3=010) with out_ready=1 -> next cycle out_valid=1, memory_en=1, store_size=10, we_reg=0; back-to-back ADDIs stream one per cycle.
- LW rd=5 issued, then ADD rs1=5, LOAD_LAT=2 -> stall=1 and in_ready=0 for 2 cycles, ADD captured on cycle 3; independent ADD rs1=6 is not stalled.
- out_ready=0 for 3 cycles while valid -> bundle stable, in_ready=0; out_ready=1 -> a queued JAL is captured the same cycle, then appears with jump=1, pcControl=1.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no capture; a prior LW scoreboard entry is still enforced.
- instrType=111 -> illegal=1, we_reg=0; ADDI with rd=0 -> we_reg=0; AUIPC -> aluAsel=0, wdSelect=00.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered control decode stage with load-use scoreboard
module ctrl_decode_stage #(
  parameter int REG_AW          = 5,
  parameter int LOAD_LAT        = 2,
  parameter bit ZERO_RD_NOWRITE = 1'b1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        instrType,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              we_reg,
  output logic              pcControl,
  output logic              memory_en,
  output logic              aluAsel,
  output logic              aluBsel,
  output logic              jump,
  output logic              branch,
  output logic [1:0]        wdSelect,
  output logic [1:0]        store_size,
  output logic              illegal,
  output logic [REG_AW-1:0] out_rd,
  output logic              stall
);

  localparam logic [2:0] TYPE_U = 3'b001;
  localparam logic [2:0] TYPE_J = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b011;
  localparam logic [2:0] TYPE_I = 3'b100;
  localparam logic [2:0] TYPE_S = 3'b101;
  localparam logic [2:0] TYPE_R = 3'b110;

  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic       we_reg;
    logic       pc_control;
    logic       memory_en;
    logic       alu_asel;
    logic       alu_bsel;
    logic       jump;
    logic       branch;
    logic [1:0] wd_select;
    logic [1:0] store_size;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    we_reg: 1'b0, pc_control: 1'b0, memory_en: 1'b0, alu_asel: 1'b1,
    alu_bsel: 1'b0, jump: 1'b0, branch: 1'b0, wd_select: 2'b00,
    store_size: 2'b11, illegal: 1'b0
  };

  ctrl_t             dec;
  logic              use_rs1, use_rs2;
  logic              rs1_hit, rs2_hit;
  logic              capture, out_fire, held_is_load, sb_insert;

  ctrl_t             bundle_q, bundle_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  logic              out_valid_q, out_valid_d;

  // scoreboard: index 0 is the newest load, index LOAD_LAT-1 the oldest
  logic [LOAD_LAT-1:0] sb_v_q, sb_v_d;
  logic [REG_AW-1:0]   sb_rd_q [LOAD_LAT];
  logic [REG_AW-1:0]   sb_rd_d [LOAD_LAT];

  // decode the instruction class into the control bundle and source usage
  always_comb begin
    dec     = CTRL_DEFAULT;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (instrType)
      TYPE_U: begin
        dec.we_reg = 1'b1;
        if (op == OP_AUIPC) begin
          dec.alu_asel  = 1'b0;
          dec.wd_select = 2'b00;
        end else begin
          dec.wd_select = 2'b11;
        end
      end
      TYPE_J: begin
        dec.we_reg     = 1'b1;
        dec.pc_control = 1'b1;
        dec.alu_asel   = 1'b0;
        dec.jump       = 1'b1;
      end
      TYPE_B: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec.branch     = 1'b1;
        dec.pc_control = 1'b1;
        dec.alu_asel   = 1'b0;
        dec.wd_select  = 2'b10;
      end
      TYPE_I: begin
        use_rs1 = 1'b1;
        if (op == OP_JALR) begin
          dec.we_reg     = 1'b1;
          dec.pc_control = 1'b1;
          dec.wd_select  = 2'b10;
          dec.alu_asel   = 1'b0;
          dec.jump       = 1'b1;
        end else if (op == OP_LOAD) begin
          dec.we_reg    = 1'b1;
          dec.wd_select = 2'b01;
          dec.memory_en = 1'b1;
        end else if (op == OP_IMM) begin
          dec.we_reg = 1'b1;
        end
      end
      TYPE_S: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.memory_en = 1'b1;
        case (funct3)
          3'b000:  dec.store_size = 2'b00;
          3'b001:  dec.store_size = 2'b01;
          3'b010:  dec.store_size = 2'b10;
          default: dec.store_size = 2'b11;
        endcase
      end
      TYPE_R: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.alu_bsel = 1'b1;
        dec.we_reg   = !((op == OP_SYSTEM) || (op == OP_FENCE));
      end
      default: dec.illegal = 1'b1;
    endcase
    if (ZERO_RD_NOWRITE && (rd == '0)) dec.we_reg = 1'b0;
  end

  // compare the used sources against every live scoreboard entry
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] == rs1)) rs1_hit = 1'b1;
      if (sb_v_q[i] && (sb_rd_q[i] == rs2)) rs2_hit = 1'b1;
    end
  end

  assign stall = in_valid & ((use_rs1 & (rs1 != '0) & rs1_hit) |
                             (use_rs2 & (rs2 != '0) & rs2_hit));
  assign in_ready     = (~out_valid_q | out_ready) & ~stall & ~flush;
  assign capture      = in_valid & in_ready;
  assign out_fire     = out_valid_q & out_ready & ~flush;
  assign held_is_load = bundle_q.we_reg & bundle_q.memory_en & (bundle_q.wd_select == 2'b01);
  assign sb_insert    = out_fire & held_is_load;

  // output register next state; bundle fields hold when nothing is captured
  always_comb begin
    bundle_d    = bundle_q;
    out_rd_d    = out_rd_q;
    out_valid_d = out_valid_q;
    if (capture) begin
      bundle_d    = dec;
      out_rd_d    = rd;
      out_valid_d = 1'b1;
    end else if (flush || out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // scoreboard ages one slot per cycle; a load entering execute lands at the head
  always_comb begin
    sb_v_d  = '0;
    sb_rd_d = '{default: '0};
    for (int i = LOAD_LAT - 1; i > 0; i--) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
    sb_v_d[0]  = sb_insert;
    sb_rd_d[0] = sb_insert ? out_rd_q : '0;
  end

  // state registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= CTRL_DEFAULT;
      out_rd_q    <= '0;
      sb_v_q      <= '0;
      sb_rd_q     <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      out_rd_q    <= out_rd_d;
      sb_v_q      <= sb_v_d;
      sb_rd_q     <= sb_rd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rd     = out_rd_q;
  assign we_reg     = bundle_q.we_reg;
  assign pcControl  = bundle_q.pc_control;
  assign memory_en  = bundle_q.memory_en;
  assign aluAsel    = bundle_q.alu_asel;
  assign aluBsel    = bundle_q.alu_bsel;
  assign jump       = bundle_q.jump;
  assign branch     = bundle_q.branch;
  assign wdSelect   = bundle_q.wd_select;
  assign store_size = bundle_q.store_size;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - randomized bench for ctrl_decode_stage against a reference model
module tb_ctrl_decode_stage;
  localparam int LAT = 2;

  logic       CLK = 1'b0;
  logic       reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [6:0] op;
  logic [2:0] instrType, funct3;
  logic [4:0] rd, rs1, rs2, out_rd;
  logic       we_reg, pcControl, memory_en, aluAsel, aluBsel, jump, branch, illegal, stall;
  logic [1:0] wdSelect, store_size;

  always #5 CLK = ~CLK;

  ctrl_decode_stage #(.REG_AW(5), .LOAD_LAT(LAT), .ZERO_RD_NOWRITE(1'b1)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .instrType(instrType), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .we_reg(we_reg), .pcControl(pcControl),
    .memory_en(memory_en), .aluAsel(aluAsel), .aluBsel(aluBsel), .jump(jump), .branch(branch),
    .wdSelect(wdSelect), .store_size(store_size), .illegal(illegal), .out_rd(out_rd), .stall(stall)
  );

  typedef struct packed {
    logic we, pc, mem, asel, bsel, jmp, br;
    logic [1:0] wd, ss;
    logic ill;
  } exp_t;

  localparam exp_t EXP_DEF = '{we:0, pc:0, mem:0, asel:1, bsel:0, jmp:0, br:0, wd:2'b00, ss:2'b11, ill:0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference decode taken straight from the decode table
  function automatic exp_t ref_decode(input logic [2:0] ty, input logic [6:0] o,
                                      input logic [2:0] f3, input logic [4:0] d);
    exp_t e = EXP_DEF;
    if (ty == 3'd1) begin
      e.we = 1;
      if (o == 7'b0010111) e.asel = 0; else e.wd = 2'b11;
    end else if (ty == 3'd2) begin
      e.we = 1; e.pc = 1; e.asel = 0; e.jmp = 1;
    end else if (ty == 3'd3) begin
      e.br = 1; e.pc = 1; e.asel = 0; e.wd = 2'b10;
    end else if (ty == 3'd4) begin
      if (o == 7'b1100111) begin e.we = 1; e.pc = 1; e.wd = 2'b10; e.asel = 0; e.jmp = 1; end
      else if (o == 7'b0000011) begin e.we = 1; e.wd = 2'b01; e.mem = 1; end
      else if (o == 7'b0010011) e.we = 1;
    end else if (ty == 3'd5) begin
      e.mem = 1;
      e.ss = (f3 < 3'd3) ? f3[1:0] : 2'b11;
    end else if (ty == 3'd6) begin
      e.bsel = 1;
      e.we = !(o == 7'b1110011 || o == 7'b0001111);
    end else begin
      e.ill = 1;
    end
    if (d == 0) e.we = 0;
    return e;
  endfunction

  // model state: held bundle plus, per register, the last cycle a pending load still blocks it
  bit         m_known = 0;
  bit         m_valid;
  exp_t       m_b;
  logic [4:0] m_rd;
  bit         m_load;
  int         busy_until [32];
  int         cyc = 0;

  task automatic step(input bit rst, input bit iv, input bit fl, input bit ordy,
                      input logic [2:0] ty, input logic [6:0] o, input logic [2:0] f3,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      output bit st);
    bit u1, u2, haz, ir, cap, fire;
    reset = rst; in_valid = iv; flush = fl; out_ready = ordy;
    instrType = ty; op = o; funct3 = f3; rd = d; rs1 = s1; rs2 = s2;
    #1;
    if (m_known) begin
      check_eq("out_valid", out_valid, m_valid);
      check_eq("we_reg", we_reg, m_b.we);
      check_eq("pcControl", pcControl, m_b.pc);
      check_eq("memory_en", memory_en, m_b.mem);
      check_eq("aluAsel", aluAsel, m_b.asel);
      check_eq("aluBsel", aluBsel, m_b.bsel);
      check_eq("jump", jump, m_b.jmp);
      check_eq("branch", branch, m_b.br);
      check_eq("wdSelect", wdSelect, m_b.wd);
      check_eq("store_size", store_size, m_b.ss);
      check_eq("illegal", illegal, m_b.ill);
      check_eq("out_rd", out_rd, m_rd);
    end
    u1  = (ty == 3'd3) || (ty == 3'd4) || (ty == 3'd5) || (ty == 3'd6);
    u2  = (ty == 3'd3) || (ty == 3'd5) || (ty == 3'd6);
    haz = iv && ((u1 && s1 != 0 && cyc <= busy_until[s1]) ||
                 (u2 && s2 != 0 && cyc <= busy_until[s2]));
    ir  = (!m_valid || ordy) && !haz && !fl;
    if (!rst && m_known) begin
      check_eq("stall", stall, haz);
      check_eq("in_ready", in_ready, ir);
    end
    st = stall;
    @(posedge CLK);
    if (rst) begin
      m_known = 1; m_valid = 0; m_b = EXP_DEF; m_rd = 0; m_load = 0;
      for (int i = 0; i < 32; i++) busy_until[i] = -1;
    end else if (m_known) begin
      cap  = iv && ir;
      fire = m_valid && ordy && !fl;
      if (fire && m_load) busy_until[m_rd] = cyc + LAT;
      if (cap) begin
        m_b = ref_decode(ty, o, f3, d); m_rd = d; m_valid = 1;
        m_load = (ty == 3'd4) && (o == 7'b0000011) && (d != 0);
      end else if (fl || fire) begin
        m_valid = 0;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  logic [6:0] ops [11] = '{7'b0010111, 7'b0110111, 7'b1101111, 7'b1100011, 7'b1100111,
                           7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1110011, 7'b0001111};

  initial begin
    bit st;
    int stalls;
    logic [2:0] ty;
    logic [6:0] o;
    reset = 1; in_valid = 0; flush = 0; out_ready = 0;
    instrType = 0; op = 0; funct3 = 0; rd = 0; rs1 = 0; rs2 = 0;
    @(negedge CLK);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    // SW then back-to-back ADDIs
    step(0, 1, 0, 1, 3'd5, 7'b0100011, 3'd2, 5'd0, 5'd1, 5'd2, st);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 1, 3'd4, 7'b0010011, 3'd0, 5'(i), 5'd0, 5'd0, st);
    // LW x5 issued, then dependent ADD must wait LAT cycles
    step(0, 1, 0, 1, 3'd4, 7'b0000011, 3'd2, 5'd5, 5'd0, 5'd0, st);
    step(0, 0, 0, 1, 3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, st);
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 1, 3'd6, 7'b0110011, 3'd0, 5'd7, 5'd5, 5'd0, st);
      if (!st) break;
      stalls++;
    end
    check_eq("lw_use_stall_cycles", stalls, LAT);
    step(0, 1, 0, 1, 3'd6, 7'b0110011, 3'd0, 5'd8, 5'd6, 5'd0, st);
    // back-pressure with a queued JAL
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3'd2, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, st);
    step(0, 1, 0, 1, 3'd2, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, st);
    step(0, 0, 0, 1, 3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, st);
    // flush with a live LW entry and a held instruction
    step(0, 1, 0, 1, 3'd4, 7'b0000011, 3'd0, 5'd9, 5'd0, 5'd0, st);
    step(0, 1, 0, 1, 3'd4, 7'b0010011, 3'd0, 5'd3, 5'd0, 5'd0, st);
    step(0, 1, 1, 1, 3'd6, 7'b0110011, 3'd0, 5'd4, 5'd9, 5'd0, st);
    step(0, 1, 0, 1, 3'd6, 7'b0110011, 3'd0, 5'd4, 5'd9, 5'd0, st);
    // illegal class, rd=0 write suppression, AUIPC
    step(0, 1, 0, 1, 3'd7, 7'b0110011, 3'd0, 5'd3, 5'd0, 5'd0, st);
    step(0, 1, 0, 1, 3'd4, 7'b0010011, 3'd0, 5'd0, 5'd0, 5'd0, st);
    step(0, 1, 0, 1, 3'd1, 7'b0010111, 3'd0, 5'd4, 5'd0, 5'd0, st);
    step(0, 0, 0, 1, 3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, st);
    // randomized traffic with loads weighted up and occasional flush/reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        ty = 3'd4; o = 7'b0000011;
      end else begin
        ty = 3'($urandom_range(0, 7)); o = ops[$urandom_range(0, 10)];
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, ty, o, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), st);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
